// File: rtl/storage_rr_scheduler_if.sv
// Bus between the four storage_control requesters, the round-robin scheduler
// and the storage memory port.
// slave  = scheduler side, master = requester/memory side.
interface storage_rr_scheduler_if #(
    parameter int ADDR_W = 8
);
    logic [3:0]              req;
    logic [4*(4+ADDR_W)-1:0] number_and_addr;
    logic [3:0]              grant;
    logic                    mem_ce;
    logic [ADDR_W-1:0]       mem_addr;
    logic [3:0]              mem_id;
    logic                    txn_done;
    logic [3:0]              done;
    logic                    timeout_err;
    logic                    busy;

    modport slave (
        input  req, number_and_addr, txn_done,
        output grant, mem_ce, mem_addr, mem_id, done, timeout_err, busy
    );

    modport master (
        output req, number_and_addr, txn_done,
        input  grant, mem_ce, mem_addr, mem_id, done, timeout_err, busy
    );
endinterface

// File: rtl/storage_rr_scheduler.sv
// Round-robin scheduler sharing one storage port between four requesters.
// Each transaction runs IDLE -> ISSUE -> WAIT -> RELEASE. A watchdog in WAIT
// aborts a hung access after TIMEOUT cycles.
// Optional statistics counters are enabled by defining STORAGE_SCHED_STATS_EN.
module storage_rr_scheduler #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    storage_rr_scheduler_if.slave    bus
`ifdef STORAGE_SCHED_STATS_EN
    ,
    input  logic                     stats_clr,
    output logic [63:0]              grant_cnt,
    output logic [7:0]               timeout_cnt
`endif
);
    localparam int WORD_W = 4 + ADDR_W;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [1:0]        r_ptr;
    logic [1:0]        r_win;
    logic [3:0]        r_grant;
    logic [ADDR_W-1:0] r_memAddr;
    logic [3:0]        r_memId;
    logic [TO_W-1:0]   r_wd;
    logic              r_success;

    logic [WORD_W-1:0] w_words [4];
    logic [7:0]        w_reqTwice;
    logic [3:0]        w_rot;
    logic [1:0]        w_off;
    logic [1:0]        w_winIdx;
    logic              w_reqAny;
    logic              w_wdExpired;

    // Split the packed request words and pick the first requester at or after the pointer
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_words[k] = bus.number_and_addr[k*WORD_W +: WORD_W];
        end
        w_reqAny   = |bus.req;
        w_reqTwice = {bus.req, bus.req} >> r_ptr;
        w_rot      = w_reqTwice[3:0];
        w_off      = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = 2'(k);
            end
        end
        w_winIdx    = r_ptr + w_off;
        w_wdExpired = (r_wd == TO_LAST);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; a completion in the final watchdog cycle still counts as success
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:    if (w_reqAny) w_nextState = S_ISSUE;
            S_ISSUE:   w_nextState = S_WAIT;
            S_WAIT:    if (bus.txn_done || w_wdExpired) w_nextState = S_RELEASE;
            S_RELEASE: w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    // Grant/address latching, watchdog and pointer rotation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= 2'd0;
            r_win     <= 2'd0;
            r_grant   <= 4'd0;
            r_memAddr <= '0;
            r_memId   <= 4'd0;
            r_wd      <= '0;
            r_success <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_reqAny) begin
                        r_grant   <= 4'b0001 << w_winIdx;
                        r_win     <= w_winIdx;
                        r_memAddr <= w_words[w_winIdx][ADDR_W-1:0];
                        r_memId   <= w_words[w_winIdx][WORD_W-1:ADDR_W];
                    end
                end
                S_ISSUE: begin
                    r_wd <= '0;
                end
                S_WAIT: begin
                    if (bus.txn_done) begin
                        r_success <= 1'b1;
                    end else if (w_wdExpired) begin
                        r_success <= 1'b0;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_RELEASE: begin
                    r_grant <= 4'd0;
                    r_ptr   <= r_win + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        bus.grant       = r_grant;
        bus.mem_ce      = (r_state == S_ISSUE);
        bus.mem_addr    = r_memAddr;
        bus.mem_id      = r_memId;
        bus.done        = (r_state == S_RELEASE && r_success) ? r_grant : 4'd0;
        bus.timeout_err = (r_state == S_RELEASE) && !r_success;
        bus.busy        = (r_state != S_IDLE);
    end

`ifdef STORAGE_SCHED_STATS_EN
    logic [15:0] r_grantCnt [4];
    logic [7:0]  r_timeoutCnt;

    // Saturating per-requester grant counts and timeout count; clear beats increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_grantCnt[k] <= 16'd0;
            end
            r_timeoutCnt <= 8'd0;
        end else if (stats_clr) begin
            for (int k = 0; k < 4; k++) begin
                r_grantCnt[k] <= 16'd0;
            end
            r_timeoutCnt <= 8'd0;
        end else begin
            if (r_state == S_ISSUE && r_grantCnt[r_win] != 16'hFFFF) begin
                r_grantCnt[r_win] <= r_grantCnt[r_win] + 16'd1;
            end
            if (r_state == S_RELEASE && !r_success && r_timeoutCnt != 8'hFF) begin
                r_timeoutCnt <= r_timeoutCnt + 8'd1;
            end
        end
    end

    // Flatten the counters onto the output buses
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            grant_cnt[k*16 +: 16] = r_grantCnt[k];
        end
        timeout_cnt = r_timeoutCnt;
    end
`endif
endmodule

// File: doc/storage_rr_scheduler.md
Name: storage_rr_scheduler

Overview:
Shares a single storage port between four storage_control requesters with round-robin arbitration. It latches the winner's 12-bit number_and_addr word, issues one storage access, waits for txn_done and pulses a per-requester done. A watchdog aborts hung transactions. It sits between the four storage_control instances and the storage memory, in place of the bare 4-way arbiter plus the valid/data OR-mux.

Parameters:
ADDR_W, 8, storage address width; low bits of each number_and_addr word.
TIMEOUT, 64, WAIT-state cycles before abort; legal range 2..(2**TO_W - 1).
TO_W, 8, watchdog counter width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req  input  4  req[i] = request from requester i+1, level, held until done
number_and_addr  input  4*(4+ADDR_W)  word i = bits [(i+1)*12-1 : i*12]; [11:8] requester number, [7:0] address
grant  output  4  one-hot grant, held IDLE-exit through RELEASE
mem_ce  output  1  storage access strobe, exactly one cycle per transaction
mem_addr  output  ADDR_W  latched address of granted requester
mem_id  output  4  latched requester number of granted word
txn_done  input  1  storage completion, sampled only in WAIT
done  output  4  one-cycle pulse to the granted requester on success
timeout_err  output  1  one-cycle pulse on watchdog abort
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, grant=0, mem_ce=0, mem_addr=0, mem_id=0, done=0, timeout_err=0, busy=0, priority pointer ptr=0 (requester 1 highest), watchdog=0.
- All outputs are registered or decoded from registered state. No combinational path from req or txn_done to any output.
- IDLE: if req!=0, pick the first set bit scanning ptr, ptr+1, ... mod 4. On the next edge:
  - grant = one-hot winner;
  - mem_addr and mem_id are latched from the winner's word;
  - go to ISSUE.
  - If req==0, stay in IDLE.
- ISSUE: mem_ce=1 for this cycle only, watchdog cleared; next state is WAIT.
- WAIT: mem_ce=0.
  - If txn_done=1: next cycle done[winner]=1, go to RELEASE.
  - Else if watchdog==TIMEOUT-1: next cycle timeout_err=1, done stays 0, go to RELEASE.
  - Else watchdog+1.
  - If txn_done and timeout occur in the same cycle, txn_done wins.
- RELEASE: grant still held, done/timeout_err pulse visible. On exit:
  - grant=0;
  - ptr = (winner+1) mod 4, identical on success and on timeout;
  - next state is IDLE.
  - This cycle gives storage_control time to drop req.
- Latency:
  - req to grant and mem_ce: 1 cycle.
  - txn_done to done: 1 cycle.
  - Minimum of 4 cycles per transaction, so back-to-back service runs at 1 transaction per 4 cycles.
- Dropping req while granted does not cancel; the transaction runs to completion or timeout.
- txn_done outside WAIT is ignored.
- A req bit still set in IDLE after its own RELEASE is re-arbitrated normally. It gets lowest priority on that round.
- mem_addr and mem_id hold their values after a transaction until the next grant.

Optional Feature:
STORAGE_SCHED_STATS_EN
- Defined:
  - Adds input stats_clr (1 bit, synchronous, clears all counters).
  - Adds output grant_cnt (4*16 bits), one saturating 16-bit count per requester. Each count increments on entry to ISSUE for that requester.
  - Adds output timeout_cnt (8 bits, saturating). It increments with each timeout_err.
  - All counters reset to 0 on rst.
  - If stats_clr and an increment fall in the same cycle, clear wins.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Single request: req=4'b0001, word0=12'h1A5, txn_done 3 cycles after mem_ce. Required: grant=0001 one cycle after req; mem_ce one cycle with mem_addr=8'hA5, mem_id=4'h1; done=0001 one cycle after txn_done; grant=0 the cycle after; ptr=1.
- All four requests held with txn_done returned immediately. Required: grants in order 0001, 0010, 0100, 1000, 0001; exactly 4 cycles between mem_ce pulses.
- Fairness: req=4'b0101 held for 6 transactions. Required: strict alternation 0001, 0100, 0001, ...
- Timeout with TIMEOUT=64 and txn_done never asserted. Required: timeout_err pulse exactly 64 cycles after WAIT entry; done=0; then the next requester is granted.
- Async reset mid-WAIT: rst=1 for 1 cycle between clock edges. Required: all outputs 0 immediately; IDLE; ptr=0; a later txn_done is ignored.
- Corner events:
  - txn_done pulsed while in IDLE: required no done pulse.
  - txn_done and timeout in the same cycle: required done only.
  - With STORAGE_SCHED_STATS_EN defined: grant_cnt saturates at 16'hFFFF, and stats_clr zeroes all counts.
